// File: rtl/logic_pkg.sv
// Shared constants for the logic-result output stage: op codes, datapath width
// and the occupancy encodings used by the 2-entry skid buffer.
package logic_pkg;

    localparam int LOGIC_W = 32;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } skid_state_t;

endpackage

// File: rtl/skid_buf2.sv
// Generic 2-entry valid/ready skid buffer. The output slot drives o_data; the
// skid slot absorbs one beat when the consumer stalls, so o_ready can be a
// register that never depends on i_ready.
//
// state | meaning
// EMPTY | output slot empty, skid empty
// ONE   | output slot full, skid empty
// FULL  | output slot and skid both full, upstream stalled
module skid_buf2
    import logic_pkg::*;
#(
    parameter int            PW      = 8,
    parameter logic [PW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [PW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [PW-1:0] o_data
);

    skid_state_t   r_state;
    skid_state_t   w_next;
    logic          r_in_ready;
    logic [PW-1:0] r_out;
    logic [PW-1:0] r_skid;
    logic          w_acc;
    logic          w_dlv;
    logic          w_load_out;
    logic          w_load_skid;
    logic          w_skid_to_out;

    assign w_acc   = i_valid & r_in_ready;
    assign w_dlv   = o_valid & i_ready;
    assign o_valid = (r_state != EMPTY);
    assign o_ready = r_in_ready;
    assign o_data  = r_out;

    // Occupancy register; ready is registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != FULL);
        end
    end

    // Next occupancy and slot load strobes
    always_comb begin
        w_next        = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_acc) begin
                    w_next     = ONE;
                    w_load_out = 1'b1;
                end
            end
            ONE: begin
                if (w_acc && w_dlv) begin
                    w_load_out = 1'b1;
                end else if (w_acc) begin
                    w_next      = FULL;
                    w_load_skid = 1'b1;
                end else if (w_dlv) begin
                    w_next = EMPTY;
                end
            end
            FULL: begin
                if (w_dlv) begin
                    w_next        = ONE;
                    w_skid_to_out = 1'b1;
                end
            end
            default: w_next = EMPTY;
        endcase
    end

    // Slot storage; output slot keeps its last value once drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= RST_VAL;
            r_skid <= '0;
        end else begin
            if (w_load_out) begin
                r_out <= i_data;
            end else if (w_skid_to_out) begin
                r_out <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_data;
            end
        end
    end

endmodule

// File: rtl/logic_res_stage.sv
// Registered output stage behind the 32-bit bitwise units. Picks one unit
// result by op code at accept time, attaches the zero flag (and parity when
// LOGIC_RES_PARITY_EN is defined) and buffers the bundle in a 2-entry skid
// buffer so the flags always travel with their data.
module logic_res_stage
    import logic_pkg::*;
#(
    parameter int W   = LOGIC_W,
    parameter int OPW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   i_and_res,
    input  logic [W-1:0]   i_or_res,
    input  logic [W-1:0]   i_xor_res,
    input  logic [W-1:0]   i_nor_res,
    input  logic [OPW-1:0] i_op,
    input  logic           i_in_valid,
    output logic           o_in_ready,
    output logic [W-1:0]   o_res,
    output logic           o_zero,
    output logic           o_out_valid,
    input  logic           i_out_ready
`ifdef LOGIC_RES_PARITY_EN
    ,
    output logic           o_parity
`endif
);

`ifdef LOGIC_RES_PARITY_EN
    localparam int PW = W + 2;
`else
    localparam int PW = W + 1;
`endif
    // Reset payload: result 0 with the zero flag set
    localparam logic [PW-1:0] RST_PAYLOAD = {{(PW-1){1'b0}}, 1'b1} << W;

    logic [W-1:0]  w_sel;
    logic          w_zero;
    logic [PW-1:0] w_payload;
    logic [PW-1:0] w_out;

    // Full-decode op select over the four unit results
    always_comb begin
        w_sel = '0;
        case (i_op)
            OP_AND:  w_sel = i_and_res;
            OP_OR:   w_sel = i_or_res;
            OP_XOR:  w_sel = i_xor_res;
            OP_NOR:  w_sel = i_nor_res;
            default: w_sel = '0;
        endcase
    end

    assign w_zero = (w_sel == '0);

`ifdef LOGIC_RES_PARITY_EN
    assign w_payload = {^w_sel, w_zero, w_sel};
    assign o_parity  = w_out[W+1];
`else
    assign w_payload = {w_zero, w_sel};
`endif

    assign o_res  = w_out[W-1:0];
    assign o_zero = w_out[W];

    skid_buf2 #(
        .PW      (PW),
        .RST_VAL (RST_PAYLOAD)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_in_valid),
        .o_ready (o_in_ready),
        .i_data  (w_payload),
        .o_valid (o_out_valid),
        .i_ready (i_out_ready),
        .o_data  (w_out)
    );

endmodule

// File: tb/tb_logic_res_stage.sv
module tb_logic_res_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] and_r, or_r, xor_r, nor_r;
    logic [1:0]  op;
    logic        in_valid;
    logic        out_ready;
    logic        in_ready;
    logic [31:0] res;
    logic        zero;
    logic        out_valid;
`ifdef LOGIC_RES_PARITY_EN
    logic        parity;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_dlv = 0;
    logic [31:0] mq[$];

    always #5 clk = ~clk;

    logic_res_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_and_res   (and_r),
        .i_or_res    (or_r),
        .i_xor_res   (xor_r),
        .i_nor_res   (nor_r),
        .i_op        (op),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .o_res       (res),
        .o_zero      (zero),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready)
`ifdef LOGIC_RES_PARITY_EN
        ,
        .o_parity    (parity)
`endif
    );

    // Reference: the selected unit's operation applied to the two operands
    function automatic logic [31:0] ref_pick(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    logic [31:0] cur_a, cur_b;

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o, input logic v);
        cur_a = a; cur_b = b;
        and_r = a & b; or_r = a | b; xor_r = a ^ b; nor_r = ~(a | b);
        op = o; in_valid = v;
    endtask

    // One clock: the model is a FIFO of capacity 2 (ready while it holds < 2)
    task automatic tick();
        bit acc, dlv;
        logic [31:0] v;
        acc = in_valid && (mq.size() < 2);
        dlv = out_ready && (mq.size() > 0);
        v = ref_pick(op, cur_a, cur_b);
        @(posedge clk);
        if (dlv) begin void'(mq.pop_front()); n_dlv++; end
        if (acc) mq.push_back(v);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(32'h0, 32'h0, 2'd0, 1'b0);
        #12;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (res !== 32'h0) begin n_err++; $display("FAIL reset_res: got %h expected 0", res); end
        n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL reset_zero: got %b expected 1", zero); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        drive(32'h5, 32'h5, 2'b00, 1'b1);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", out_valid); end
        n_cmp++; if (res !== 32'h00000005) begin n_err++; $display("FAIL single_res: got %h expected 00000005", res); end
        n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL single_zero: got %b expected 0", zero); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_zero_flag();
        out_ready = 1'b1;
        drive(32'h0, 32'h0, 2'b01, 1'b1);
        tick();
        n_cmp++; if (res !== 32'h0 || zero !== 1'b1) begin n_err++; $display("FAIL zero_or: got res=%h zero=%b expected 0/1", res, zero); end
        drive(32'h0, 32'h0, 2'b11, 1'b1);
        tick();
        n_cmp++; if (res !== 32'hffffffff || zero !== 1'b0) begin n_err++; $display("FAIL zero_nor: got res=%h zero=%b expected ffffffff/0", res, zero); end
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] a1, a2, a3;
        a1 = 32'h1111_0001; a2 = 32'h2222_0002; a3 = 32'h3333_0003;
        out_ready = 1'b0;
        drive(a1, 32'h0, 2'b01, 1'b1); tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after1: got %b expected 1", in_ready); end
        drive(a2, 32'h0, 2'b01, 1'b1); tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_after2: got %b expected 0", in_ready); end
        drive(a3, 32'h0, 2'b01, 1'b1);
        repeat (2) begin
            tick();
            n_cmp++; if (in_ready !== 1'b0 || res !== a1) begin n_err++; $display("FAIL bp_hold: got ready=%b res=%h expected 0/%h", in_ready, res, a1); end
        end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (res !== a2 || in_ready !== 1'b1 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_second: got res=%h ready=%b valid=%b expected %h/1/1", res, in_ready, out_valid, a2); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (res !== a3 || out_valid !== 1'b1) begin n_err++; $display("FAIL bp_third: got res=%h valid=%b expected %h/1", res, out_valid, a3); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_streaming();
        int start;
        start = n_dlv;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive($urandom, $urandom, 2'($urandom_range(0, 3)), 1'b1);
            tick();
            n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin n_err++; $display("FAIL stream_hs[%0d]: got valid=%b ready=%b expected 1/1", i, out_valid, in_ready); end
            n_cmp++; if (mq.size() != 1 || res !== mq[0] || zero !== (mq[0] == 32'h0)) begin n_err++; $display("FAIL stream_res[%0d]: got %h/%b expected %h", i, res, zero, mq.size() ? mq[0] : 32'hx); end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (n_dlv - start != 100) begin n_err++; $display("FAIL stream_count: got %0d expected 100", n_dlv - start); end
    endtask

    task automatic test_random_handshake();
        for (int i = 0; i < 400; i++) begin
            drive($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            n_cmp++; if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin n_err++; $display("FAIL rand_hs[%0d]: got valid=%b ready=%b occ=%0d", i, out_valid, in_ready, mq.size()); end
            if (mq.size() > 0) begin
                n_cmp++; if (res !== mq[0] || zero !== (mq[0] == 32'h0)) begin n_err++; $display("FAIL rand_res[%0d]: got %h/%b expected %h", i, res, zero, mq[0]); end
`ifdef LOGIC_RES_PARITY_EN
                n_cmp++; if (parity !== ^mq[0]) begin n_err++; $display("FAIL rand_parity[%0d]: got %b expected %b", i, parity, ^mq[0]); end
`endif
            end
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        drive(32'hdead_beef, 32'h0, 2'b01, 1'b1); tick();
        drive(32'hcafe_f00d, 32'h0, 2'b01, 1'b1); tick();
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL mid_prefill: got ready=%b valid=%b expected 0/1", in_ready, out_valid); end
        rst_n = 1'b0;
        #1;
        mq.delete();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_hs: got valid=%b ready=%b expected 0/1", out_valid, in_ready); end
        n_cmp++; if (res !== 32'h0 || zero !== 1'b1) begin n_err++; $display("FAIL mid_reset_data: got res=%h zero=%b expected 0/1", res, zero); end
        #2;
        rst_n = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_stale: got valid=%b expected 0", out_valid); end
    endtask

`ifdef LOGIC_RES_PARITY_EN
    task automatic test_parity();
        out_ready = 1'b1;
        drive(32'h7, 32'h0, 2'b10, 1'b1); tick();
        n_cmp++; if (parity !== 1'b1) begin n_err++; $display("FAIL parity_7: got %b expected 1", parity); end
        drive(32'h3, 32'h0, 2'b10, 1'b1); tick();
        n_cmp++; if (parity !== 1'b0) begin n_err++; $display("FAIL parity_3: got %b expected 0", parity); end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_zero_flag();
        test_backpressure();
        test_streaming();
        test_random_handshake();
`ifdef LOGIC_RES_PARITY_EN
        test_parity();
`endif
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
